// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential restoring unsigned divider, one quotient bit per clock
//
// Purpose: computes q = a / b and r = a % b over WIDTH iterations of a
// restoring shift-subtract loop. Results are registered and held until the
// next completion or reset. Divide by zero takes the normal path
// (q = all ones, r = a) and raises dz.
//
// Ports:
//   clk   in   1      system clock, rising edge
//   rst   in   1      asynchronous active-high reset
//   start in   1      request, sampled only while not busy
//   a     in   WIDTH  dividend, latched on the accepting edge
//   b     in   WIDTH  divisor, latched on the accepting edge
//   busy  out  1      division in progress (exactly WIDTH cycles)
//   done  out  1      one-cycle pulse, q/r/dz valid
//   q     out  WIDTH  quotient
//   r     out  WIDTH  remainder
//   dz    out  1      last completed division had b == 0

module div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;    // dividend bits shift out the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;    // one extra bit so the trial subtract cannot overflow
  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;  // low for the first edge after reset release
  logic             done_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             dz_q;

  logic [WIDTH:0]   rem_shift_d;
  logic [WIDTH:0]   diff_d;
  logic             qbit_d;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] dvd_d;

  // One restoring iteration. The partial remainder is always below the
  // divisor, so the shifted value fits WIDTH+1 bits and diff_d[WIDTH] is a
  // reliable borrow/sign indicator.
  always_comb begin
    rem_shift_d = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    diff_d      = rem_shift_d - {1'b0, dvs_q};
    qbit_d      = ~diff_d[WIDTH];
    rem_d       = qbit_d ? diff_d : rem_shift_d;
    dvd_d       = {dvd_q[WIDTH-2:0], qbit_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && armed_q) begin
            dvd_q   <= a;
            dvs_q   <= b;
            rem_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH - 1);
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            q_q     <= dvd_d;
            r_q     <= rem_d[WIDTH-1:0];
            dz_q    <= (dvs_q == '0);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The DONE cycle doubles as an accept slot for back-to-back requests.
          if (start) begin
            dvd_q   <= a;
            dvs_q   <= b;
            rem_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH - 1);
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq
module tb_div_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dz;

  div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   bcnt   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    e.a = aa;
    e.b = bb;
    if (bb == '0) begin
      e.q  = '1;
      e.r  = aa;
      e.dz = 1'b1;
    end else begin
      e.q  = aa / bb;
      e.r  = aa % bb;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives one start pulse; the edge inside step() is the accepting edge.
  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb);
    a     = aa;
    b     = bb;
    start = 1'b1;
    sb.push_back(model(aa, bb));
    step();
    cyc   = 0;
    start = 1'b0;
  endtask

  // Waits (bounded) for done, checks latency from the accept edge and the
  // scoreboard head; optionally checks the relation q*b+r == a.
  task automatic wait_done(input string tag, input bit relation);
    exp_t e;
    bcnt = 0;
    while (!done && cyc < W + 8) begin
      if (busy) bcnt++;
      step();
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(W));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      if (done) begin
        chk({tag, "_q"},  64'(q),  64'(e.q));
        chk({tag, "_r"},  64'(r),  64'(e.r));
        chk({tag, "_dz"}, 64'(dz), 64'(e.dz));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        if (relation && e.b != '0) begin
          chk({tag, "_qb_plus_r"}, 64'(q) * 64'(e.b) + 64'(r), 64'(e.a));
          chk({tag, "_r_lt_b"}, 64'(r < e.b), 64'(1));
        end
      end
    end
  endtask

  initial begin
    logic [W-1:0] hold_q;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_q",    64'(q),    64'(0));
    chk("reset_r",    64'(r),    64'(0));
    chk("reset_dz",   64'(dz),   64'(0));
    rst = 1'b0;
    step();

    // Basic 100 / 7
    issue(16'd100, 16'd7);
    chk("basic_busy_after_accept", 64'(busy), 64'(1));
    wait_done("basic", 1'b1);
    chk("basic_busy_cycles", 64'(bcnt), 64'(W));
    step();
    chk("basic_done_single", 64'(done), 64'(0));
    hold_q = q;
    step();
    step();
    chk("basic_hold_q", 64'(q), 64'(hold_q));

    // Extremes
    issue(16'hFFFF, 16'h0001);
    wait_done("ffff_by_1", 1'b1);
    step();
    issue(16'h0005, 16'hFFFF);
    wait_done("5_by_ffff", 1'b1);
    step();
    issue(16'h0000, 16'h0003);
    wait_done("0_by_3", 1'b1);
    step();

    // Divide by zero, then a normal op clears dz
    issue(16'h04D2, 16'h0000);
    wait_done("div_zero", 1'b0);
    step();
    issue(16'd9, 16'd3);
    wait_done("after_dz", 1'b1);
    step();

    // Starts during RUN are ignored, operands not re-sampled
    issue(16'd1000, 16'd33);
    while (cyc < 3) step();
    a = 16'd1; b = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 10) step();
    a = 16'd2; b = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    a = 16'd0; b = 16'd0;
    wait_done("ignored_start", 1'b1);
    step();
    chk("ignored_start_no_extra_busy", 64'(busy), 64'(0));
    step();

    // Back-to-back: start held through the DONE cycle
    issue(16'd500, 16'd11);
    a = 16'd777; b = 16'd25; start = 1'b1;
    wait_done("b2b_first", 1'b1);
    sb.push_back(model(16'd777, 16'd25));
    step();
    cyc   = 0;
    start = 1'b0;
    chk("b2b_busy_after_accept", 64'(busy), 64'(1));
    chk("b2b_done_single", 64'(done), 64'(0));
    wait_done("b2b_second", 1'b1);
    step();

    // Reset mid-run: abandon, outputs clear immediately
    issue(16'd100, 16'd7);
    while (cyc < 8) step();
    void'(sb.pop_front());
    rst = 1'b1;
    #1;
    chk("midrst_q",    64'(q),    64'(0));
    chk("midrst_r",    64'(r),    64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) chk("midrst_no_done", 64'(done), 64'(0));
    end
    // start on the reset-release edge is ignored
    rst = 1'b0; a = 16'd50; b = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_on_release_ignored", 64'(busy), 64'(0));
    step();
    issue(16'd50, 16'd5);
    wait_done("after_reset", 1'b1);
    step();

    // Strided sweep over 0..255 x 0..255
    for (int i = 0; i <= 51; i++) begin
      for (int j = 0; j <= 37; j++) begin
        issue(W'(i * 5), (j == 37) ? W'(255) : W'(j * 7));
        wait_done("sweep", 1'b1);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
